// File: rtl/bla_sub_seq.sv
// Multi-cycle borrow-lookahead subtractor: diff = a - b - bin, one nibble per clock.
// The borrow is registered between nibbles. Valid/ready handshake on input and output.
module bla_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [3:0] na, nb, g, p, dn;
  logic [4:0] br;

  // Select the current nibble and resolve its borrows with a flat lookahead from br[0]
  always_comb begin
    na = '0;
    nb = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        na = a_q[4*i +: 4];
        nb = b_q[4*i +: 4];
      end
    end
    g = ~na & nb;
    p = ~(na ^ nb);
    br[0] = br_q;
    br[1] = g[0] | (p[0] & br[0]);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br[0]);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br[0]);
    dn = na ^ nb ^ br[3:0];
  end

  // Next-state and datapath updates; visible outputs only change when a result completes
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) res_d[4*i +: 4] = dn;
        end
        br_d  = br[4];
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NIB - 1)) begin
          diff_d  = res_d;
          bout_d  = br[4];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (res_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bla_sub_seq.sv
// Directed and randomized checks for bla_sub_seq at WIDTH = 16, 8 and 4.
module tb_bla_sub_seq;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, bin_i;
  logic [15:0] a16, b16;

  logic ir16, ov16, bo16, of16, z16;
  logic ir8, ov8, bo8, of8, z8;
  logic ir4, ov4, bo4, of4, z4;
  logic [15:0] d16;
  logic [7:0]  d8;
  logic [3:0]  d4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bla_sub_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a16), .b(b16), .bin(bin_i),
    .out_valid(ov16), .out_ready(out_ready), .diff(d16), .bout(bo16), .ovf(of16), .zero(z16));
  bla_sub_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .a(a16[7:0]), .b(b16[7:0]), .bin(bin_i),
    .out_valid(ov8), .out_ready(out_ready), .diff(d8), .bout(bo8), .ovf(of8), .zero(z8));
  bla_sub_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .a(a16[3:0]), .b(b16[3:0]), .bin(bin_i),
    .out_valid(ov4), .out_ready(out_ready), .diff(d4), .bout(bo4), .ovf(of4), .zero(z4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: {zero, ovf, bout, diff}
  function automatic logic [18:0] ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic bi);
    int unsigned mask, av, bv, dv;
    logic bo, ov, zr;
    mask = (32'd1 << w) - 1;
    av = 32'(a) & mask;
    bv = 32'(b) & mask;
    dv = (av - bv - 32'(bi)) & mask;
    bo = (av < bv + 32'(bi));
    ov = (av[w-1] != bv[w-1]) && (dv[w-1] != av[w-1]);
    zr = (dv == 0);
    return {zr, ov, bo, dv[15:0]};
  endfunction

  // One full 16-bit operation; checks latency, result and handshake release
  task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    int k;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(ir16), 32'd1);
    a16 = a; b16 = b; bin_i = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a16 = 16'(~a); b16 = 16'(~b); bin_i = ~bi;
    k = 0;
    while (!ov16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd4);
    chk({nm, "_diff"}, 32'(d16), 32'(ed));
    chk({nm, "_bout"}, 32'(bo16), 32'(eb));
    chk({nm, "_ovf"}, 32'(of16), 32'(eo));
    chk({nm, "_zero"}, 32'(z16), 32'(ez));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_release"}, {30'd0, ov16, ir16}, 32'b01);
  endtask

  vec_t vecs[8];

  initial begin
    int k, lat4, lat8, lat16, bad_ov;
    logic [15:0] sa, sb, hold_d;
    logic sbin;
    logic [18:0] r;
    logic [3:0] hold_f;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0004, 16'h0004, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin_i = 1'b0; a16 = '0; b16 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(ir16), 32'd1);
    chk("reset_out_valid", 32'(ov16), 32'd0);
    chk("reset_outputs", {12'd0, z16, of16, bo16, d16, 1'b0}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
           vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero);

    // Backpressure: result held in DONE while a new request waits
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0FFF; bin_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a16 = 16'h0100; b16 = 16'h0001; bin_i = 1'b1;
    k = 0;
    while (!ov16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_first_latency", 32'(k), 32'd4);
    hold_d = d16;
    hold_f = {ov16, bo16, of16, z16};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_diff%0d", c), 32'(d16), 32'h0235);
      chk($sformatf("bp_hold_flags%0d", c), {28'd0, ov16, bo16, of16, z16}, {28'd0, hold_f});
      chk($sformatf("bp_hold_ready%0d", c), 32'(ir16), 32'd0);
    end
    chk("bp_hold_same", 32'(d16), 32'(hold_d));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {30'd0, ov16, ir16}, 32'b01);
    @(negedge clk);
    in_valid = 1'b0;
    a16 = 16'hDEAD; b16 = 16'hBEEF; bin_i = 1'b0;
    k = 0;
    while (!ov16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_second_latency", 32'(k), 32'd4);
    chk("bp_second_diff", 32'(d16), 32'h00FE);
    chk("bp_second_flags", {29'd0, bo16, of16, z16}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset two RUN cycles into an operation with a pending borrow
    @(negedge clk);
    a16 = 16'h0000; b16 = 16'h0001; bin_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov16), 32'd0);
    chk("rst_in_ready", 32'(ir16), 32'd1);
    chk("rst_outputs", {12'd0, z16, of16, bo16, d16, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad_ov = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov16) bad_ov++;
    end
    chk("rst_no_stale_valid", 32'(bad_ov), 32'd0);
    op16("post_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

    // Random sweep across all three widths sharing the same operands
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      sa = 16'($urandom);
      sb = 16'($urandom);
      sbin = 1'($urandom);
      if (it == 0) begin sa = 16'h0000; sb = 16'hFFFF; sbin = 1'b1; end
      a16 = sa; b16 = sb; bin_i = sbin; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); bin_i = 1'($urandom);
      lat4 = -1; lat8 = -1; lat16 = -1;
      for (int c = 0; c < 12; c++) begin
        if (ov4 && lat4 < 0) lat4 = c;
        if (ov8 && lat8 < 0) lat8 = c;
        if (ov16 && lat16 < 0) lat16 = c;
        @(negedge clk);
      end
      chk($sformatf("sw%0d_lat4", it), 32'(lat4), 32'd1);
      chk($sformatf("sw%0d_lat8", it), 32'(lat8), 32'd2);
      chk($sformatf("sw%0d_lat16", it), 32'(lat16), 32'd4);
      r = ref_sub(4, sa, sb, sbin);
      chk($sformatf("sw%0d_w4", it), {13'd0, z4, of4, bo4, 12'd0, d4}, {13'd0, r});
      r = ref_sub(8, sa, sb, sbin);
      chk($sformatf("sw%0d_w8", it), {13'd0, z8, of8, bo8, 8'd0, d8}, {13'd0, r});
      r = ref_sub(16, sa, sb, sbin);
      chk($sformatf("sw%0d_w16", it), {13'd0, z16, of16, bo16, d16}, {13'd0, r});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
